// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32I multicycle control FSM (fetch..writeback) with MemReq/MemReady wait states, sticky illegal-op trap and retired-instruction counter
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Op,
  input  logic             MemReady,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic             Trap,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  state_t state, next;
  logic retire;
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= FETCH;
      Retired <= '0;
    end else begin
      state <= next;
      if (retire) Retired <= Retired + 1'b1;
    end
  assign retire = state == MEMWB || state == ALUWB || state == BEQ || (state == MEMWRITE && MemReady);
  assign Trap   = state == TRAP;
  assign State  = state;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = MemReady ? DECODE : FETCH;
      DECODE:   next = (Op == 7'b0000011 || Op == 7'b0100011) ? MEMADR :
                       Op == 7'b0110011 ? EXECR :
                       Op == 7'b0010011 ? EXECI :
                       Op == 7'b1100011 ? BEQ :
                       Op == 7'b1101111 ? JAL : TRAP;
      MEMADR:   next = Op == 7'b0000011 ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: next = MemReady ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      JAL:      next = ALUWB;
      TRAP:     next = TRAP;
      default:  next = FETCH;
    endcase
  end
  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        PCUpdate  = MemReady;
        ALUSrcB   = MemReady ? 2'b10 : 2'b00;
        ResultSrc = MemReady ? 2'b10 : 2'b00;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      IRWrite  = 1'b0;
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_sequencer;
  logic clk = 1'b0, reset, MemReady;
  logic [6:0] Op;
  logic PCUpdate, Branch, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite, Trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0] State;
  logic [31:0] Retired;
  logic PCUpdate4, Branch4, IRWrite4, AdrSrc4, MemReq4, MemWrite4, RegWrite4, Trap4;
  logic [1:0] ALUSrcA4, ALUSrcB4, ResultSrc4, ALUOp4;
  logic [3:0] State4, Retired4;
  logic [14:0] obs;
  localparam logic [6:0] OPL = 7'b0000011, OPS = 7'b0100011, OPR = 7'b0110011,
                         OPI = 7'b0010011, OPB = 7'b1100011, OPJ = 7'b1101111;
  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] c;
    logic        tr;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, mret = 0;
  always #5 clk = ~clk;
  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemReq(MemReq), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .Trap(Trap), .State(State), .Retired(Retired)
  );
  multicycle_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCUpdate(PCUpdate4), .Branch(Branch4), .IRWrite(IRWrite4), .AdrSrc(AdrSrc4),
    .MemReq(MemReq4), .MemWrite(MemWrite4), .RegWrite(RegWrite4),
    .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .ResultSrc(ResultSrc4), .ALUOp(ALUOp4),
    .Trap(Trap4), .State(State4), .Retired(Retired4)
  );
  assign obs = {PCUpdate, Branch, IRWrite, AdrSrc, MemReq, MemWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp};
  function automatic logic [14:0] ctl(input int s, input logic mr, input logic rst);
    logic [14:0] c;
    case (s)
      0:  c = mr ? 15'b101_0_100_00_10_10_00 : 15'b000_0_100_00_00_00_00;
      1:  c = 15'b000_0_000_01_01_00_00;
      2:  c = 15'b000_0_000_10_01_00_00;
      3:  c = 15'b000_1_100_00_00_00_00;
      4:  c = 15'b000_0_001_00_00_01_00;
      5:  c = 15'b000_1_110_00_00_00_00;
      6:  c = 15'b000_0_000_10_00_00_10;
      7:  c = 15'b000_0_000_10_01_00_10;
      8:  c = 15'b000_0_001_00_00_00_00;
      9:  c = 15'b010_0_000_10_00_00_01;
      10: c = 15'b100_0_000_01_10_00_00;
      default: c = '0;
    endcase
    return rst ? c : c & ~15'b111_0_111_00_00_00_00;
  endfunction
  task automatic cyc(input logic [6:0] op, input logic mr, input logic rst, input int s);
    exp_t e;
    logic [31:0] r;
    Op = op;
    MemReady = mr;
    reset = rst;
    q.push_back('{st: 4'(s), c: ctl(s, mr, rst), tr: (s == 11), ret: mret});
    @(negedge clk);
    e = q.pop_front();
    r = e.ret;
    tests++;
    assert (State === e.st) else begin fails++; $error("FAIL state got %0d exp %0d", State, e.st); end
    tests++;
    assert (obs === e.c) else begin fails++; $error("FAIL ctrl st=%0d got %b exp %b", e.st, obs, e.c); end
    tests++;
    assert (Trap === e.tr) else begin fails++; $error("FAIL trap st=%0d got %b exp %b", e.st, Trap, e.tr); end
    tests++;
    assert (Retired === r) else begin fails++; $error("FAIL retired got %0d exp %0d", Retired, r); end
    tests++;
    assert (Retired4 === r[3:0]) else begin fails++; $error("FAIL retired4 got %0d exp %0d", Retired4, r[3:0]); end
    if (!rst) mret = 0;
    else if (s == 4 || s == 8 || s == 9 || (s == 5 && mr)) mret++;
    @(posedge clk);
    #1;
  endtask
  task automatic alu_instr(input logic [6:0] op, input int ex);
    cyc(op, 1, 1, 0);
    cyc(op, 1, 1, 1);
    cyc(op, 1, 1, ex);
    cyc(op, 1, 1, 8);
  endtask
  initial begin
    reset = 1'b0;
    Op = 7'd0;
    MemReady = 1'b1;
    @(posedge clk);
    #1;
    alu_instr(OPI, 7);
    alu_instr(OPR, 6);
    cyc(OPL, 0, 1, 0);
    cyc(OPL, 0, 1, 0);
    cyc(OPL, 1, 1, 0);
    cyc(OPL, 1, 1, 1);
    cyc(OPL, 1, 1, 2);
    cyc(OPL, 0, 1, 3);
    cyc(OPL, 0, 1, 3);
    cyc(OPL, 0, 1, 3);
    cyc(OPL, 1, 1, 3);
    cyc(OPL, 1, 1, 4);
    cyc(OPS, 1, 1, 0);
    cyc(OPS, 1, 1, 1);
    cyc(OPS, 1, 1, 2);
    cyc(OPS, 0, 1, 5);
    cyc(OPS, 0, 1, 5);
    cyc(OPS, 1, 1, 5);
    cyc(OPB, 1, 1, 0);
    cyc(OPB, 1, 1, 1);
    cyc(OPB, 1, 1, 9);
    alu_instr(OPJ, 10);
    cyc(7'd0, 1, 1, 0);
    cyc(7'd0, 1, 1, 1);
    for (int i = 0; i < 20; i++) cyc(7'd0, 1, 1, 11);
    cyc(7'd0, 1, 0, 11);
    alu_instr(OPI, 7);
    cyc(OPS, 1, 1, 0);
    cyc(OPS, 1, 1, 1);
    cyc(OPS, 1, 1, 2);
    cyc(OPS, 0, 1, 5);
    cyc(OPS, 0, 0, 5);
    for (int i = 0; i < 17; i++) alu_instr(OPI, 7);
    cyc(OPI, 1, 1, 0);
    tests++;
    assert (Retired4 === 4'd1) else begin fails++; $error("FAIL wrap4 got %0d exp 1", Retired4); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
